atm_multi_acct: RTL and testbench

- Parametrised ATM transaction core; successor to the single-configuration ATM block.
- Holds NUM_ACCTS accounts, each with balance, PIN, failed-try counter, lock bit and daily-withdrawal accumulator.
- Authenticates a card session, then executes withdraw, deposit, balance, PIN change, transfer and logout under a start handshake.
- Adds lockout, session timeout and overflow/limit checks; sits between the front-panel controller and the display/dispenser logic.

---
 rtl/atm_multi_acct_if.sv | 28 ++
 rtl/atm_multi_acct.sv | 135 +++++++++++++
 tb/tb_atm_multi_acct.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_multi_acct_if.sv
// atm_multi_acct_if: request/result bundle; master = front panel (drives requests), slave = ATM core (drives results)
interface atm_multi_acct_if #(
  parameter int ACC_W = 4,
  parameter int PIN_W = 16,
  parameter int AMT_W = 32
);
  logic             start;
  logic [2:0]       operation;
  logic [ACC_W-1:0] acc_num;
  logic [ACC_W-1:0] dst_acc;
  logic [PIN_W-1:0] pin;
  logic [PIN_W-1:0] new_pin;
  logic [AMT_W-1:0] amount;
  logic             day_clr;
  logic [AMT_W-1:0] balance;
  logic             success;
  logic             busy;
  logic             locked;
  logic [2:0]       state;
  modport master (
    output start, operation, acc_num, dst_acc, pin, new_pin, amount, day_clr,
    input  balance, success, busy, locked, state
  );
  modport slave (
    input  start, operation, acc_num, dst_acc, pin, new_pin, amount, day_clr,
    output balance, success, busy, locked, state
  );
endinterface

// File: rtl/atm_multi_acct.sv
// atm_multi_acct: multi-account ATM core; ports clk, rst (async active-low), bus (slave: requests in, registered results out)
module atm_multi_acct #(
  parameter int          NUM_ACCTS   = 16,
  parameter int          ACC_W       = 4,
  parameter int          PIN_W       = 16,
  parameter int          AMT_W       = 32,
  parameter int unsigned INIT_BAL    = 1000,
  parameter int unsigned PIN_BASE    = 123,
  parameter int unsigned PIN_STEP    = 1111,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned WD_LIMIT    = 5000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic rst,
  atm_multi_acct_if.slave bus
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {
    AUTH = 3'd0, MENU = 3'd1, EXEC = 3'd2, DONE = 3'd3, LOCKOUT = 3'd6, IDLE = 3'd7
  } state_t;
  state_t st, nxt;
  logic [AMT_W-1:0] bal    [NUM_ACCTS];
  logic [AMT_W-1:0] wd_tot [NUM_ACCTS];
  logic [PIN_W-1:0] pins   [NUM_ACCTS];
  logic [TRY_W-1:0] tries  [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock;
  logic [ACC_W-1:0] acc, dst;
  logic [PIN_W-1:0] pin_l, npin;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [TO_W-1:0]  tcnt;
  logic             acc_ok, dst_ok, pin_ok, try_out, wd_ok, dep_ok, xfer_ok, ex_ok;
  logic [AMT_W-1:0] sbal, dbal, stot, res_bal;
  logic [AMT_W:0]   wd_sum, dep_sum, xfer_sum;
  assign bus.state = st;
  always_comb begin
    acc_ok  = {1'b0, acc} < (ACC_W+1)'(NUM_ACCTS);
    dst_ok  = {1'b0, dst} < (ACC_W+1)'(NUM_ACCTS) && dst != acc;
    sbal    = bal[acc];
    dbal    = bal[dst];
    stot    = wd_tot[acc];
    pin_ok  = pins[acc] == pin_l;
    try_out = tries[acc] == TRY_W'(MAX_TRIES - 1);
    wd_sum  = {1'b0, stot} + {1'b0, amt};
    dep_sum = {1'b0, sbal} + {1'b0, amt};
    xfer_sum = {1'b0, dbal} + {1'b0, amt};
    wd_ok   = amt != '0 && amt <= sbal && wd_sum <= (AMT_W+1)'(WD_LIMIT);
    dep_ok  = amt != '0 && !dep_sum[AMT_W];
    xfer_ok = dst_ok && amt != '0 && amt <= sbal && !xfer_sum[AMT_W];
    ex_ok   = op == 3'd1 ? wd_ok :
              op == 3'd2 ? npin != '0 :
              op == 3'd3 ? 1'b1 :
              op == 3'd4 ? xfer_ok :
              op == 3'd5 ? dep_ok :
              op == 3'd6;
    res_bal = (op == 3'd1 && wd_ok) || (op == 3'd4 && xfer_ok) ? sbal - amt :
              op == 3'd5 && dep_ok ? dep_sum[AMT_W-1:0] : sbal;
    nxt     = st == IDLE ? (bus.start ? AUTH : IDLE) :
              st == AUTH ? (!acc_ok || lock[acc] || (!pin_ok && try_out) ? LOCKOUT : pin_ok ? MENU : IDLE) :
              st == MENU ? (bus.start ? EXEC : tcnt == TO_W'(TIMEOUT_CYC - 1) ? IDLE : MENU) :
              st == EXEC ? DONE :
              st == DONE ? (op == 3'd6 ? IDLE : MENU) :
              IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      bus.balance <= '0;
      bus.success <= 1'b0;
      bus.busy    <= 1'b0;
      bus.locked  <= 1'b0;
      acc         <= '0;
      dst         <= '0;
      pin_l       <= '0;
      npin        <= '0;
      op          <= '0;
      amt         <= '0;
      tcnt        <= '0;
      lock        <= '0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal[i]    <= AMT_W'(INIT_BAL);
        pins[i]   <= PIN_W'(PIN_BASE + PIN_STEP * i);
        tries[i]  <= '0;
        wd_tot[i] <= '0;
      end
    end else begin
      st         <= nxt;
      bus.busy   <= nxt inside {AUTH, EXEC, DONE, LOCKOUT};
      bus.locked <= nxt == LOCKOUT;
      tcnt       <= st == MENU && !bus.start ? tcnt + 1'b1 : '0;
      if (st == IDLE && bus.start) begin
        acc   <= bus.acc_num;
        pin_l <= bus.pin;
      end
      if (st == MENU && bus.start) begin
        op   <= bus.operation;
        amt  <= bus.amount;
        npin <= bus.new_pin;
        dst  <= bus.dst_acc;
      end
      if (st == AUTH) begin
        bus.success <= nxt == MENU;
        if (nxt == MENU) begin
          bus.balance <= sbal;
          tries[acc]  <= '0;
        end else if (acc_ok && !lock[acc]) begin
          tries[acc] <= tries[acc] + 1'b1;
          if (try_out) lock[acc] <= 1'b1;
        end
      end
      if (st == EXEC) begin
        bus.success <= ex_ok;
        bus.balance <= res_bal;
        if (op == 3'd1 && wd_ok) begin
          bal[acc]    <= res_bal;
          wd_tot[acc] <= wd_sum[AMT_W-1:0];
        end
        if (op == 3'd5 && dep_ok) bal[acc] <= res_bal;
        if (op == 3'd4 && xfer_ok) begin
          bal[acc] <= res_bal;
          bal[dst] <= xfer_sum[AMT_W-1:0];
        end
        if (op == 3'd2 && npin != '0) pins[acc] <= npin;
      end
      if (bus.day_clr)
        for (int i = 0; i < NUM_ACCTS; i++) wd_tot[i] <= '0;
      if (nxt == IDLE) begin
        bus.success <= 1'b0;
        bus.balance <= '0;
      end
    end
  end
endmodule

// File: tb/tb_atm_multi_acct.sv
// tb_atm_multi_acct: randomized and directed checks of atm_multi_acct against an account-ledger model
module tb_atm_multi_acct;
  localparam int N = 16;
  localparam longint unsigned MAXB = 64'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  atm_multi_acct_if bus ();
  atm_multi_acct dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  longint unsigned mb [N];
  longint unsigned mw [N];
  int unsigned     mp [N];
  int              mt [N];
  bit              ml [N];
  int              cur;
  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      mb[i] = 1000;
      mw[i] = 0;
      mp[i] = (123 + 1111 * i) % 65536;
      mt[i] = 0;
      ml[i] = 0;
    end
    cur = 0;
  endfunction
  function automatic int m_auth(int a, int unsigned p);
    if (a >= N || ml[a]) return 6;
    if (p == mp[a]) begin
      mt[a] = 0;
      cur = a;
      return 1;
    end
    mt[a]++;
    if (mt[a] >= 3) begin
      ml[a] = 1;
      return 6;
    end
    return 7;
  endfunction
  function automatic bit m_op(int o, longint unsigned a, int unsigned np, int d, bit dc);
    bit s;
    case (o)
      1: begin
        s = a != 0 && a <= mb[cur] && mw[cur] + a <= 5000;
        if (s) begin mb[cur] -= a; mw[cur] += a; end
      end
      2: begin
        s = np != 0;
        if (s) mp[cur] = np;
      end
      3: s = 1;
      4: begin
        s = d < N && d != cur && a != 0 && a <= mb[cur] && mb[d] + a <= MAXB;
        if (s) begin mb[cur] -= a; mb[d] += a; end
      end
      5: begin
        s = a != 0 && mb[cur] + a <= MAXB;
        if (s) mb[cur] += a;
      end
      6: s = 1;
      default: s = 0;
    endcase
    if (dc) for (int i = 0; i < N; i++) mw[i] = 0;
    return s;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.day_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    m_reset();
  endtask
  task automatic auth(input int a, input int unsigned p, output logic [2:0] st, output logic s,
                      output logic [31:0] b, output logic lk);
    bus.start = 1'b1;
    bus.acc_num = 4'(a);
    bus.pin = 16'(p);
    tick();
    bus.start = 1'b0;
    tick();
    st = bus.state;
    s = bus.success;
    b = bus.balance;
    lk = bus.locked;
    if (st == 3'd6) tick();
  endtask
  task automatic op(input int o, input longint unsigned a, input int unsigned np, input int d, input bit dc,
                    output logic [2:0] st, output logic s, output logic [31:0] b);
    bus.start = 1'b1;
    bus.operation = 3'(o);
    bus.amount = 32'(a);
    bus.new_pin = 16'(np);
    bus.dst_acc = 4'(d);
    tick();
    bus.start = 1'b0;
    bus.day_clr = dc;
    tick();
    bus.day_clr = 1'b0;
    st = bus.state;
    s = bus.success;
    b = bus.balance;
    tick();
  endtask
  task automatic test_reset();
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.state !== 3'd7) begin miscompares++; $display("FAIL reset_state got %0d exp 7", bus.state); end
    vectors++;
    if ({bus.success, bus.busy, bus.locked} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got s=%b busy=%b lk=%b exp 000", bus.success, bus.busy, bus.locked);
    end
    vectors++;
    if (bus.balance !== 32'd0) begin miscompares++; $display("FAIL reset_balance got %0d exp 0", bus.balance); end
    rst = 1'b1;
    tick();
    m_reset();
  endtask
  task automatic test_sequence();
    int exp_seq[6] = '{7, 0, 1, 2, 3, 1};
    logic [2:0] obs[6];
    logic s;
    logic [31:0] b;
    int e;
    bit es;
    e = m_auth(1, 1234);
    es = m_op(3, 0, 0, 0, 0);
    obs[0] = bus.state;
    bus.start = 1'b1; bus.acc_num = 4'd1; bus.pin = 16'd1234;
    tick(); obs[1] = bus.state;
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL seq_busy_auth got %b exp 1", bus.busy); end
    bus.start = 1'b0;
    tick(); obs[2] = bus.state;
    bus.start = 1'b1; bus.operation = 3'd3;
    tick(); obs[3] = bus.state;
    bus.start = 1'b0;
    tick(); obs[4] = bus.state; s = bus.success; b = bus.balance;
    tick(); obs[5] = bus.state;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs[i] !== 3'(exp_seq[i])) begin
        miscompares++;
        $display("FAIL seq_state[%0d] got %0d exp %0d", i, obs[i], exp_seq[i]);
      end
    end
    vectors++;
    if (s !== 1'b1 || b !== 32'd1000 || e != 1 || !es) begin
      miscompares++;
      $display("FAIL seq_result got s=%b bal=%0d exp s=1 bal=1000", s, b);
    end
    es = m_op(6, 0, 0, 0, 0);
    op(6, 0, 0, 0, 0, obs[0], s, b);
    vectors++;
    if (obs[0] !== 3'd3 || s !== 1'b1 || bus.state !== 3'd7 || bus.success !== 1'b0) begin
      miscompares++;
      $display("FAIL logout got done_st=%0d s=%b then st=%0d s=%b exp 3 1 7 0", obs[0], s, bus.state, bus.success);
    end
  endtask
  task automatic test_deposit();
    logic [2:0] st;
    logic s, lk;
    logic [31:0] b;
    int e;
    bit es;
    e = m_auth(1, 1234);
    auth(1, 1234, st, s, b, lk);
    vectors++;
    if (st !== 3'(e) || b !== 32'(mb[1])) begin miscompares++; $display("FAIL dep_auth got st=%0d bal=%0d exp %0d %0d", st, b, e, mb[1]); end
    es = m_op(5, 1000, 0, 0, 0);
    op(5, 1000, 0, 0, 0, st, s, b);
    vectors++;
    if (st !== 3'd3 || s !== es || b !== 32'd2000 || b !== 32'(mb[1])) begin
      miscompares++;
      $display("FAIL deposit got st=%0d s=%b bal=%0d exp 3 %b 2000", st, s, b, es);
    end
    es = m_op(3, 0, 0, 0, 0);
    op(3, 0, 0, 0, 0, st, s, b);
    vectors++;
    if (s !== 1'b1 || b !== 32'd2000) begin miscompares++; $display("FAIL dep_balance got s=%b bal=%0d exp 1 2000", s, b); end
    es = m_op(6, 0, 0, 0, 0);
    op(6, 0, 0, 0, 0, st, s, b);
  endtask
  task automatic test_lockout();
    logic [2:0] st;
    logic s, lk;
    logic [31:0] b;
    int e;
    for (int t = 0; t < 4; t++) begin
      int unsigned p = t < 3 ? 2346 : 2345;
      e = m_auth(2, p);
      auth(2, p, st, s, b, lk);
      vectors++;
      if (st !== 3'(e) || s !== 1'b0 || lk !== (e == 6) || bus.state !== 3'd7) begin
        miscompares++;
        $display("FAIL lockout_try%0d got st=%0d s=%b lk=%b exp st=%0d s=0 lk=%b", t, st, s, lk, e, e == 6);
      end
    end
  endtask
  task automatic test_withdraw();
    int tbl[12][3] = '{'{1, 600, 0}, '{1, 500, 0}, '{3, 0, 1}, '{5, 9000, 0}, '{1, 4500, 0}, '{1, 600, 0},
                       '{3, 0, 1}, '{1, 600, 0}, '{1, 600, 1}, '{5, 5000, 0}, '{1, 4000, 0}, '{1, 0, 0}};
    logic [2:0] st;
    logic s, lk;
    logic [31:0] b;
    int e;
    bit es;
    do_reset();
    e = m_auth(1, 1234);
    auth(1, 1234, st, s, b, lk);
    for (int i = 0; i < 12; i++) begin
      es = m_op(tbl[i][0], longint'(tbl[i][1]), 0, 0, tbl[i][2] != 0);
      op(tbl[i][0], longint'(tbl[i][1]), 0, 0, tbl[i][2] != 0, st, s, b);
      vectors++;
      if (st !== 3'd3 || s !== es || b !== 32'(mb[1])) begin
        miscompares++;
        $display("FAIL withdraw[%0d] got st=%0d s=%b bal=%0d exp 3 %b %0d", i, st, s, b, es, mb[1]);
      end
    end
    es = m_op(6, 0, 0, 0, 0);
    op(6, 0, 0, 0, 0, st, s, b);
  endtask
  task automatic test_transfer();
    int tbl[8][4] = '{'{4, 300, 2, 0}, '{4, 50, 1, 0}, '{4, 100, 15, 0}, '{4, 0, 3, 0},
                      '{4, 5000, 3, 0}, '{2, 0, 0, 0}, '{7, 5, 0, 0}, '{0, 5, 0, 0}};
    int chk[3] = '{1, 2, 15};
    logic [2:0] st;
    logic s, lk;
    logic [31:0] b;
    int e;
    bit es;
    do_reset();
    e = m_auth(1, 1234);
    auth(1, 1234, st, s, b, lk);
    for (int i = 0; i < 8; i++) begin
      es = m_op(tbl[i][0], longint'(tbl[i][1]), int'(tbl[i][3]), tbl[i][2], 0);
      op(tbl[i][0], longint'(tbl[i][1]), int'(tbl[i][3]), tbl[i][2], 0, st, s, b);
      vectors++;
      if (st !== 3'd3 || s !== es || b !== 32'(mb[1])) begin
        miscompares++;
        $display("FAIL xfer[%0d] got st=%0d s=%b bal=%0d exp 3 %b %0d", i, st, s, b, es, mb[1]);
      end
    end
    es = m_op(6, 0, 0, 0, 0);
    op(6, 0, 0, 0, 0, st, s, b);
    for (int i = 0; i < 3; i++) begin
      e = m_auth(chk[i], mp[chk[i]]);
      auth(chk[i], mp[chk[i]], st, s, b, lk);
      vectors++;
      if (st !== 3'd1 || s !== 1'b1 || b !== 32'(mb[chk[i]]) || e != 1) begin
        miscompares++;
        $display("FAIL xfer_acct%0d got st=%0d s=%b bal=%0d exp 1 1 %0d", chk[i], st, s, b, mb[chk[i]]);
      end
      es = m_op(6, 0, 0, 0, 0);
      op(6, 0, 0, 0, 0, st, s, b);
    end
  endtask
  task automatic test_overflow_timeout();
    logic [2:0] st;
    logic s, lk;
    logic [31:0] b;
    longint unsigned a;
    int e;
    bit es;
    e = m_auth(1, mp[1]);
    auth(1, mp[1], st, s, b, lk);
    a = MAXB - mb[1];
    es = m_op(5, a, 0, 0, 0);
    op(5, a, 0, 0, 0, st, s, b);
    vectors++;
    if (s !== 1'b1 || b !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL fill got s=%b bal=%0h exp 1 ffffffff", s, b); end
    es = m_op(5, 1, 0, 0, 0);
    op(5, 1, 0, 0, 0, st, s, b);
    vectors++;
    if (s !== 1'b0 || es || b !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL overflow got s=%b bal=%0h exp 0 ffffffff", s, b); end
    repeat (254) tick();
    vectors++;
    if (bus.state !== 3'd1) begin miscompares++; $display("FAIL timeout_early got st=%0d exp 1", bus.state); end
    tick();
    vectors++;
    if (bus.state !== 3'd7 || bus.success !== 1'b0 || bus.balance !== 32'd0) begin
      miscompares++;
      $display("FAIL timeout got st=%0d s=%b bal=%0d exp 7 0 0", bus.state, bus.success, bus.balance);
    end
  endtask
  task automatic test_back_to_back();
    logic [2:0] st;
    logic s, lk;
    logic [31:0] b;
    int e;
    bit es;
    e = m_auth(3, mp[3]);
    auth(3, mp[3], st, s, b, lk);
    es = m_op(3, 0, 0, 0, 0);
    bus.start = 1'b1; bus.operation = 3'd3;
    tick();
    bus.operation = 3'd5; bus.amount = 32'd7;
    tick();
    vectors++;
    if (bus.state !== 3'd3 || bus.balance !== 32'(mb[3])) begin
      miscompares++;
      $display("FAIL b2b_done got st=%0d bal=%0d exp 3 %0d", bus.state, bus.balance, mb[3]);
    end
    bus.start = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.state !== 3'd1) begin miscompares++; $display("FAIL b2b_noqueue got st=%0d exp 1", bus.state); end
    es = m_op(3, 0, 0, 0, 0);
    op(3, 0, 0, 0, 0, st, s, b);
    vectors++;
    if (b !== 32'(mb[3])) begin miscompares++; $display("FAIL b2b_balance got %0d exp %0d", b, mb[3]); end
    es = m_op(6, 0, 0, 0, 0);
    op(6, 0, 0, 0, 0, st, s, b);
  endtask
  task automatic test_reset_mid();
    logic [2:0] st;
    logic s, lk;
    logic [31:0] b;
    int e;
    e = m_auth(1, mp[1]);
    auth(1, mp[1], st, s, b, lk);
    bus.start = 1'b1; bus.operation = 3'd5; bus.amount = 32'd500;
    tick();
    bus.start = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.state !== 3'd7 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL async_reset got st=%0d busy=%b exp 7 0", bus.state, bus.busy); end
    tick();
    rst = 1'b1;
    tick();
    m_reset();
    for (int a = 1; a < 3; a++) begin
      e = m_auth(a, mp[a]);
      auth(a, mp[a], st, s, b, lk);
      vectors++;
      if (st !== 3'd1 || b !== 32'd1000) begin miscompares++; $display("FAIL mid_reset_acct%0d got st=%0d bal=%0d exp 1 1000", a, st, b); end
      e = int'(m_op(6, 0, 0, 0, 0));
      op(6, 0, 0, 0, 0, st, s, b);
    end
  endtask
  task automatic test_random();
    logic [2:0] st;
    logic s, lk;
    logic [31:0] b;
    bit in_s = 0;
    int e, a, o, d;
    int unsigned p, np;
    longint unsigned amt;
    bit dc, es;
    do_reset();
    for (int it = 0; it < 300; it++) begin
      if (!in_s) begin
        a = $urandom_range(0, N - 1);
        p = $urandom_range(0, 9) < 8 ? mp[a] : $urandom_range(0, 65535);
        e = m_auth(a, p);
        auth(a, p, st, s, b, lk);
        vectors++;
        if (st !== 3'(e) || s !== (e == 1) || b !== (e == 1 ? 32'(mb[a]) : 32'd0)) begin
          miscompares++;
          $display("FAIL rnd_auth[%0d] acct=%0d got st=%0d s=%b bal=%0d exp %0d %b %0d", it, a, st, s, b, e, e == 1, e == 1 ? mb[a] : 0);
        end
        in_s = e == 1;
      end else begin
        o = $urandom_range(0, 9) == 0 ? 6 : $urandom_range(0, 7);
        amt = $urandom_range(0, 15) == 0 ? longint'($urandom) : longint'($urandom_range(0, 2500));
        np = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 65535);
        d = $urandom_range(0, N - 1);
        dc = $urandom_range(0, 9) == 0;
        es = m_op(o, amt, np, d, dc);
        op(o, amt, np, d, dc, st, s, b);
        vectors++;
        if (st !== 3'd3 || s !== es || b !== 32'(mb[cur])) begin
          miscompares++;
          $display("FAIL rnd_op[%0d] op=%0d amt=%0d got st=%0d s=%b bal=%0d exp 3 %b %0d", it, o, amt, st, s, b, es, mb[cur]);
        end
        if (o == 6) in_s = 0;
      end
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.operation = 3'd0;
    bus.acc_num = '0;
    bus.pin = '0;
    bus.new_pin = '0;
    bus.dst_acc = '0;
    bus.amount = '0;
    bus.day_clr = 1'b0;
    m_reset();
    test_reset();
    test_sequence();
    test_deposit();
    test_lockout();
    test_withdraw();
    test_transfer();
    test_overflow_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
